// File: rtl/mem_dump_reader_pkg.sv
// mem_dump_reader_pkg
//   Shared definitions for the memory dump reader: default address/data
//   widths and the FSM state encoding.
//   MEM_DUMP_CHECKSUM_EN widens the state to 3 bits to make room for CKSUM.
package mem_dump_reader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND   = 3'd2,
    FINISH = 3'd3,
    CKSUM  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/mem_dump_reader_xor_acc.sv
// dump_xor_acc
//   XOR accumulator for the dump checksum byte. It only exists when
//   MEM_DUMP_CHECKSUM_EN is defined; the default build has no accumulator.
//   Ports:
//     Clk   system clock
//     R     synchronous active-high reset
//     clr   clear accumulator (takes priority over en)
//     en    fold data into the accumulator
//     data  byte to accumulate
//     acc   current accumulator value
`ifdef MEM_DUMP_CHECKSUM_EN
module dump_xor_acc
  import mem_dump_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] acc
);

  always_ff @(posedge Clk) begin
    if (R || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ data;
    end
  end

endmodule
`endif

// File: rtl/mem_dump_reader.sv
// mem_dump_reader
//   Walks a byte range of a combinationally-read memory and presents each
//   byte on a valid/ready stream. One byte every two cycles when the
//   consumer is always ready (FETCH cycle, then SEND cycle).
//   Optional: MEM_DUMP_CHECKSUM_EN appends an XOR checksum byte after the
//   data bytes (also emitted for an empty dump).
//   Ports:
//     Clk, R               clock, synchronous active-high reset
//     Start                one-cycle dump request, sampled in IDLE only
//     BaseAddr, Count      first address / byte count (0..2^ADDR_W)
//     Mem_Addr, Mem_Data   memory read port (combinational read)
//     Out_Data, Out_Valid  output stream, held until Out_Ready
//     Out_Ready            consumer accept
//     Busy                 high whenever not IDLE
//     Done                 one-cycle completion pulse (in FINISH)
//
//   state  | meaning
//   IDLE   | waiting for Start
//   FETCH  | Mem_Addr driven, byte captured at the edge
//   SEND   | byte presented, waiting for Out_Ready
//   CKSUM  | checksum byte load/present (checksum build only)
//   FINISH | Done pulse, back to IDLE
module mem_dump_reader
  import mem_dump_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W:0]   Count,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem;

  // The address register drives the memory directly.
  assign Mem_Addr = addr;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic              acc_clr;
  logic              acc_en;
  logic [DATA_W-1:0] acc;

  assign acc_clr = (state == IDLE) && Start;
  // Only data handshakes are folded in; the checksum byte itself is not.
  assign acc_en  = (state == SEND) && Out_Ready;

  dump_xor_acc #(.DATA_W(DATA_W)) u_acc (
    .Clk  (Clk),
    .R    (R),
    .clr  (acc_clr),
    .en   (acc_en),
    .data (Out_Data),
    .acc  (acc)
  );
`endif

  always_ff @(posedge Clk) begin
    if (R) begin
      state     <= IDLE;
      addr      <= '0;
      rem       <= '0;
      Out_Data  <= '0;
      Out_Valid <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            Busy <= 1'b1;
            if (Count != '0) begin
              addr  <= BaseAddr;
              rem   <= Count;
              state <= FETCH;
            end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
              state <= CKSUM;
`else
              state <= FINISH;
              Done  <= 1'b1;
`endif
            end
          end
        end

        FETCH: begin
          Out_Data  <= Mem_Data;
          Out_Valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (Out_Ready) begin
            Out_Valid <= 1'b0;
            addr      <= addr + 1'b1;
            rem       <= rem - 1'b1;
            if (rem == REM_ONE) begin
`ifdef MEM_DUMP_CHECKSUM_EN
              state <= CKSUM;
`else
              state <= FINISH;
              Done  <= 1'b1;
`endif
            end else begin
              state <= FETCH;
            end
          end
        end

`ifdef MEM_DUMP_CHECKSUM_EN
        // First cycle loads the accumulator (which now includes the last
        // data byte), then it is held until accepted.
        CKSUM: begin
          if (!Out_Valid) begin
            Out_Data  <= acc;
            Out_Valid <= 1'b1;
          end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
            state     <= FINISH;
            Done      <= 1'b1;
          end
        end
`endif

        FINISH: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader
//   Self-checking bench for mem_dump_reader. A behavioural model (expected
//   byte queue snapshot of memory at Start, plus fetch/present cadence)
//   is checked against the DUT on every cycle; directed scenarios pin the
//   model with literal byte values and cycle offsets.
module tb_mem_dump_reader;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          R;
  logic          Start;
  logic [AW-1:0] BaseAddr;
  logic [AW:0]   Count;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_Data;
  logic [DW-1:0] Out_Data;
  logic          Out_Valid;
  logic          Out_Ready;
  logic          Busy;
  logic          Done;

  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  assign Mem_Data = mem[Mem_Addr];

  mem_dump_reader dut (
    .Clk       (Clk),
    .R         (R),
    .Start     (Start),
    .BaseAddr  (BaseAddr),
    .Count     (Count),
    .Mem_Addr  (Mem_Addr),
    .Mem_Data  (Mem_Data),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Busy      (Busy),
    .Done      (Done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int         cyc = 0;
  bit         chk_en = 0;
  bit         active = 0;
  bit         exp_valid = 0;
  bit         exp_busy = 0;
  bit         exp_done = 0;
  bit         rst_chk = 1;
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] xsum;
  int         start_edge = 0;
  int         first_valid_cyc = 0;
  bit         first_seen = 0;
  int         done_cyc = 0;
  int         done_cnt = 0;
  int         stall_cnt = 0;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", Busy, exp_busy);
      check("done", Done, exp_done);
      check("out_valid", Out_Valid, exp_valid);
      if (rst_chk) begin
        check("rst_out_data", Out_Data, 0);
        check("rst_mem_addr", Mem_Addr, 0);
      end
      if (exp_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL model_queue: got empty expected a pending byte");
        end else begin
          check("out_data", Out_Data, q[0]);
        end
      end
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (Out_Valid && !first_seen) begin
        first_seen = 1;
        first_valid_cyc = cyc;
      end
      if (Out_Valid && !Out_Ready) stall_cnt++;

      // predict the cycle after the coming edge
      rst_chk = 0;
      if (R) begin
        active = 0;
        q.delete();
        exp_valid = 0;
        exp_busy = 0;
        exp_done = 0;
        rst_chk = 1;
      end else if (exp_done) begin
        exp_done = 0;
        exp_busy = 0;
      end else if (!exp_busy && Start) begin
        start_edge = cyc + 1;
        first_seen = 0;
        exp_busy = 1;
        q.delete();
        xsum = 8'h00;
        for (int i = 0; i < int'(Count); i++) begin
          q.push_back(mem[8'(int'(BaseAddr) + i)]);
          xsum = xsum ^ mem[8'(int'(BaseAddr) + i)];
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        q.push_back(xsum);
`endif
        if (q.size() == 0) exp_done = 1;
        else begin
          active = 1;
          exp_valid = 0;
        end
      end else if (active) begin
        if (exp_valid) begin
          if (Out_Ready) begin
            got.push_back(Out_Data);
            void'(q.pop_front());
            exp_valid = 0;
            if (q.size() == 0) begin
              active = 0;
              exp_done = 1;
            end
          end
        end else begin
          exp_valid = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_xfer(input logic [7:0] b, input logic [8:0] c);
    BaseAddr = b;
    Count    = c;
    Start    = 1'b1;
    tick();
    Start    = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (Busy && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
    tick();
  endtask

  task automatic wait_byte2(input string name);
    int n = 0;
    while (!(Out_Valid && got.size() == 1) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no byte 2 expected byte 2 valid", name);
    end
  endtask

  task automatic pin_stream(input string name, input logic [31:0] bytes, input int nb);
    logic [31:0] b;
    b = bytes;
`ifdef MEM_DUMP_CHECKSUM_EN
    check({name, "_len"}, got.size(), nb + 1);
`else
    check({name, "_len"}, got.size(), nb);
`endif
    for (int i = 0; i < nb && i < got.size(); i++)
      check({name, "_byte"}, got[i], b[31 - 8*i -: 8]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    R = 1'b1;
    Start = 1'b0;
    BaseAddr = '0;
    Count = '0;
    Out_Ready = 1'b1;
    tick();
    chk_en = 1;
    tick();
    R = 1'b0;
    tick();

    // 1: basic 4-byte dump
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
    got.delete();
    start_xfer(8'h10, 9'd4);
    wait_idle("s1", 100);
    pin_stream("s1", 32'hA1B2C3D4, 4);
    check("s1_first_valid_ofs", first_valid_cyc - start_edge, 1);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("s1_cksum", got.size() > 4 ? got[4] : 8'hxx, 8'h04);
    check("s1_done_ofs", done_cyc - start_edge, 10);
`else
    check("s1_done_ofs", done_cyc - start_edge, 8);
`endif

    // 2: back-pressure on byte 2, plus a Start while busy that must be ignored
    got.delete();
    start_xfer(8'h10, 9'd4);
    wait_byte2("s2");
    stall_cnt = 0;
    Out_Ready = 1'b0;
    BaseAddr = 8'h55;
    Count = 9'd7;
    Start = 1'b1;
    repeat (5) tick();
    Start = 1'b0;
    Out_Ready = 1'b1;
    wait_idle("s2", 100);
    check("s2_stall_cycles", stall_cnt, 5);
    pin_stream("s2", 32'hA1B2C3D4, 4);

    // 3: address wrap
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    got.delete();
    start_xfer(8'hFE, 9'd3);
    wait_idle("s3", 100);
    pin_stream("s3", 32'h11223300, 3);

    // 4: empty dump
    got.delete();
    d0 = done_cnt;
    start_xfer(8'h40, 9'd0);
    wait_idle("s4", 100);
    check("s4_done_pulses", done_cnt - d0, 1);
`ifdef MEM_DUMP_CHECKSUM_EN
    pin_stream("s4", 32'h0, 0);
    check("s4_cksum", got.size() > 0 ? got[0] : 8'hxx, 8'h00);
`else
    check("s4_done_ofs", done_cyc - start_edge, 0);
    check("s4_len", got.size(), 0);
`endif

    // 5: reset during byte 2, then a 1-byte dump
    got.delete();
    d0 = done_cnt;
    start_xfer(8'h10, 9'd4);
    wait_byte2("s5");
    R = 1'b1;
    tick();
    R = 1'b0;
    repeat (4) tick();
    check("s5_no_done", done_cnt - d0, 0);
    got.delete();
    start_xfer(8'h12, 9'd1);
    wait_idle("s5b", 100);
    pin_stream("s5b", 32'hC3000000, 1);

    // random dumps with random back-pressure and Start spam while busy
    for (int t = 0; t < 25; t++) begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      got.delete();
      start_xfer(8'($urandom), (t % 10 == 9) ? 9'd256 : 9'($urandom_range(0, 24)));
      n = 0;
      while (Busy && n < 5000) begin
        Out_Ready = ($urandom % 4) != 0;
        Start     = Busy && !Done && (($urandom % 8) == 0);
        BaseAddr  = 8'($urandom);
        Count     = 9'($urandom_range(0, 256));
        tick();
        n++;
      end
      Start = 1'b0;
      Out_Ready = 1'b1;
      if (n >= 5000) begin
        n_chk++;
        n_fail++;
        $display("FAIL rand_timeout: got busy after %0d cycles expected idle", n);
      end
      tick();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
